// File: rtl/lcp_cmd_dispatcher.sv
// lcp_cmd_dispatcher: routes fetched instructions to NUM_UNITS execution units, tracks outstanding work, runs WAIT/HALT.
// Ports: clk, rst_n (async active-low); start pulse; instr_valid/instr_data/instr_ready fetch port;
// unit_cmd/unit_valid/unit_ready/unit_done per-unit command ports; busy, done pulse, error status.
// Define DISPATCH_PERF_EN to add the stall_cycles and instr_count outputs.
module lcp_cmd_dispatcher #(
    parameter int INSTR_W   = 128,
    parameter int NUM_UNITS = 4,
    parameter int MAX_OUT   = 4,
    parameter int CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          instr_valid,
    input  logic [INSTR_W-1:0]            instr_data,
    output logic                          instr_ready,
    output logic [NUM_UNITS*INSTR_W-1:0]  unit_cmd,
    output logic [NUM_UNITS-1:0]          unit_valid,
    input  logic [NUM_UNITS-1:0]          unit_ready,
    input  logic [NUM_UNITS-1:0]          unit_done,
    output logic                          busy,
    output logic                          done,
    output logic                          error
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [31:0]                   instr_count
`endif
);
    typedef enum logic [2:0] {IDLE, RUN, ISSUE, WAIT, DRAIN, DONE, ERROR} state_t;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);
    state_t state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q [NUM_UNITS];
    logic [CNT_W-1:0] cnt_d [NUM_UNITS];
    logic [7:0] op;
    logic [3:0] uq;
    logic [NUM_UNITS-1:0] mask, nz, hs;
    assign op   = instr_data[INSTR_W-1 -: 8];
    assign uq   = instr_q[INSTR_W-5 -: 4];
    assign mask = instr_q[INSTR_W-9 -: NUM_UNITS];
    assign instr_ready = state_q == RUN;
    assign busy  = state_q != IDLE;
    assign done  = state_q == DONE;
    assign error = state_q == ERROR;
    assign hs    = unit_valid & unit_ready;
    always_comb begin
        unit_valid = '0;
        unit_cmd   = '0;
        nz         = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            nz[i] = cnt_q[i] != '0;
            // Back-pressure: a unit at its outstanding limit is simply not offered the command.
            unit_valid[i] = state_q == ISSUE && uq == 4'(i) && cnt_q[i] != MAX_C;
            unit_cmd[i*INSTR_W +: INSTR_W] = (state_q == ISSUE && uq == 4'(i)) ? instr_q : '0;
            // Done at zero is ignored; handshake and done together cancel out.
            cnt_d[i] = cnt_q[i] + CNT_W'(hs[i]) - CNT_W'(unit_done[i] && nz[i]);
        end
    end
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            IDLE:  state_d = start ? RUN : IDLE;
            RUN: begin
                if (instr_valid) begin
                    instr_d = instr_data;
                    state_d = op == 8'h00 ? RUN :
                              (op[7:4] == 4'h1 && op[3:0] < 4'(NUM_UNITS)) ? ISSUE :
                              op == 8'hF0 ? WAIT :
                              op == 8'hFF ? DRAIN : ERROR;
                end
            end
            ISSUE: state_d = |hs ? RUN : ISSUE;
            WAIT:  state_d = |(mask & nz) ? WAIT : RUN;
            DRAIN: state_d = |nz ? DRAIN : DONE;
            DONE:  state_d = IDLE;
            ERROR: state_d = start ? RUN : ERROR;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            for (int i = 0; i < NUM_UNITS; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            for (int i = 0; i < NUM_UNITS; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`ifdef DISPATCH_PERF_EN
    logic [31:0] stall_q, stall_d, icnt_q, icnt_d;
    logic clr, stall;
    always_comb begin
        clr     = state_q == IDLE && start;
        stall   = (state_q == ISSUE && unit_valid == '0) || state_q == WAIT;
        stall_d = clr ? '0 : (stall && stall_q != '1) ? stall_q + 32'd1 : stall_q;
        icnt_d  = clr ? '0 : (instr_ready && instr_valid && icnt_q != '1) ? icnt_q + 32'd1 : icnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            icnt_q  <= '0;
        end else begin
            stall_q <= stall_d;
            icnt_q  <= icnt_d;
        end
    end
    assign stall_cycles = stall_q;
    assign instr_count  = icnt_q;
`endif
endmodule
